// File: rtl/jt12_wrqueue_if.sv
`default_nettype none
// ============================================================================
//  jt12_wrqueue_if
//  Host-side write port and register-map-side bus of the YM2612 write queue.
//  Revision: 1.0
// ============================================================================
interface jt12_wrqueue_if #(
    parameter int DW = 3
);
    logic          host_wr;
    logic          host_part;
    logic [7:0]    host_reg;
    logic [7:0]    host_data;
    logic          flush;
    logic          host_full;
    logic [DW:0]   level;
    logic          overflow;
    logic          idle;
    logic          mmr_write;
    logic [1:0]    mmr_addr;
    logic [7:0]    mmr_din;
    logic          mmr_busy;

    modport master (
        output host_wr, host_part, host_reg, host_data, flush, mmr_busy,
        input  host_full, level, overflow, idle, mmr_write, mmr_addr, mmr_din
    );

    modport slave (
        input  host_wr, host_part, host_reg, host_data, flush, mmr_busy,
        output host_full, level, overflow, idle, mmr_write, mmr_addr, mmr_din
    );
endinterface
`default_nettype wire

// File: rtl/jt12_wrqueue.sv
`default_nettype none
// ============================================================================
//  jt12_wrqueue
//  FIFO of complete {part, reg, data} writes, replayed to jt12_mmr as an
//  address write then a data write, paced by the register map's busy flag.
//  Revision: 1.0
// ============================================================================
module jt12_wrqueue #(
    parameter int DW  = 3,
    parameter int GAP = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    jt12_wrqueue_if.slave      bus
);
    localparam int            c_DEPTH    = 1 << DW;
    localparam logic [DW:0]   c_FULL     = (DW+1)'(c_DEPTH);
    localparam logic [1:0]    c_GAP_LAST = (GAP > 0) ? 2'(GAP - 1) : 2'd0;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_GAP     = 3'd2,
        S_DATA    = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [16:0]     r_mem [c_DEPTH];
    logic [DW-1:0]   r_wr_ptr, r_rd_ptr;
    logic [DW:0]     r_cnt, w_cnt_nxt;
    logic            r_full, r_overflow, r_idle;
    logic [16:0]     r_hold;
    logic [1:0]      r_gap_cnt, w_gap_cnt_nxt;
    logic            r_write, w_write_nxt;
    logic [1:0]      r_addr, w_addr_nxt;
    logic [7:0]      r_din, w_din_nxt;
    logic            w_push, w_pop, w_drop;

    // flush wins over both ends: a same-cycle push is discarded silently
    assign w_push = bus.host_wr & ~r_full & ~bus.flush;
    assign w_drop = bus.host_wr &  r_full & ~bus.flush;
    assign w_pop  = (r_state == S_IDLE) & (r_cnt != '0) & ~bus.flush;

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (bus.flush)
            w_cnt_nxt = '0;
        else if (w_push & ~w_pop)
            w_cnt_nxt = r_cnt + (DW+1)'(1);
        else if (w_pop & ~w_push)
            w_cnt_nxt = r_cnt - (DW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= {bus.host_part, bus.host_reg, bus.host_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_cnt      <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
            r_idle     <= 1'b1;
            r_hold     <= '0;
        end else begin
            if (bus.flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + DW'(1);
                if (w_pop)  r_rd_ptr <= r_rd_ptr + DW'(1);
            end
            if (w_pop)  r_hold <= r_mem[r_rd_ptr];
            if (w_drop) r_overflow <= 1'b1;
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == c_FULL);
            r_idle <= (r_cnt == '0) && (r_state == S_IDLE);
        end
    end

    // Outputs are computed from the current state and registered, so each
    // strobe appears one cycle after the state that requests it.
    always_comb begin
        w_state_nxt   = r_state;
        w_gap_cnt_nxt = r_gap_cnt;
        w_write_nxt   = 1'b0;
        w_addr_nxt    = r_addr;
        w_din_nxt     = r_din;
        case (r_state)
            S_IDLE: begin
                if (w_pop) w_state_nxt = S_ADDR;
            end
            S_ADDR: begin
                w_write_nxt   = 1'b1;
                w_addr_nxt    = {r_hold[16], 1'b0};
                w_din_nxt     = r_hold[15:8];
                w_gap_cnt_nxt = 2'd0;
                w_state_nxt   = (GAP > 0) ? S_GAP : S_DATA;
            end
            S_GAP: begin
                if (r_gap_cnt == c_GAP_LAST)
                    w_state_nxt = S_DATA;
                else
                    w_gap_cnt_nxt = r_gap_cnt + 2'd1;
            end
            S_DATA: begin
                w_write_nxt = 1'b1;
                w_addr_nxt  = {r_hold[16], 1'b1};
                w_din_nxt   = r_hold[7:0];
                w_state_nxt = S_WAIT_HI;
            end
            S_WAIT_HI: w_state_nxt = S_WAIT_LO;
            S_WAIT_LO: begin
                if (!bus.mmr_busy) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_gap_cnt <= 2'd0;
            r_write   <= 1'b0;
            r_addr    <= 2'd0;
            r_din     <= 8'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_write   <= w_write_nxt;
            r_addr    <= w_addr_nxt;
            r_din     <= w_din_nxt;
        end
    end

    assign bus.host_full = r_full;
    assign bus.level     = r_cnt;
    assign bus.overflow  = r_overflow;
    assign bus.idle      = r_idle;
    assign bus.mmr_write = r_write;
    assign bus.mmr_addr  = r_addr;
    assign bus.mmr_din   = r_din;
endmodule
`default_nettype wire

// File: tb/tb_jt12_wrqueue.sv
`default_nettype none
// ============================================================================
//  tb_jt12_wrqueue
//  Directed vectors and multi-cycle sequences against a simple busy model.
//  Revision: 1.0
// ============================================================================
module tb_jt12_wrqueue;
    localparam int DW = 3;

    logic clk = 1'b0;
    logic rst_n;

    jt12_wrqueue_if #(.DW(DW)) bus ();

    jt12_wrqueue #(.DW(DW), .GAP(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [1:0] a;
        logic [7:0] d;
        int         gap;
    } wr_t;

    typedef struct {
        logic       part;
        logic [7:0] rg;
        logic [7:0] dat;
        int         blen;
        logic [1:0] ea0;
        logic [1:0] ea1;
        int         eidle;
    } vec_t;

    wr_t log_q[$];
    int  lvl_q[$];
    int  cyc = 0;
    int  tests = 0;
    int  fails = 0;
    int  busy_len = 0;
    int  busy_cnt = 0;
    bit  force_busy = 1'b0;
    int  fall_cyc = -100;
    bit  prev_busy = 1'b0;
    int  prev_lvl = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Register-map busy: high for busy_len cycles after each data write
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                  busy_cnt <= 0;
        else if (bus.mmr_write && bus.mmr_addr[0])   busy_cnt <= busy_len;
        else if (busy_cnt != 0)                      busy_cnt <= busy_cnt - 1;
    end
    assign bus.mmr_busy = force_busy | (busy_cnt != 0);

    always @(negedge clk) begin
        if (bus.mmr_write)
            log_q.push_back('{cyc, bus.mmr_addr, bus.mmr_din, cyc - fall_cyc});
        if (prev_busy && !bus.mmr_busy) fall_cyc = cyc;
        prev_busy = bus.mmr_busy;
        if (int'(bus.level) != prev_lvl) lvl_q.push_back(int'(bus.level));
        prev_lvl = int'(bus.level);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic p, input logic [7:0] r, input logic [7:0] d);
        bus.host_wr   = 1'b1;
        bus.host_part = p;
        bus.host_reg  = r;
        bus.host_data = d;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string nm, input int maxc);
        int k = 0;
        repeat (2) @(negedge clk);
        while (!bus.idle && k < maxc) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " idle reached"}, bus.idle, 1);
    endtask

    task automatic wait_data_strobe(input string nm);
        int k = 0;
        while (!(bus.mmr_write && bus.mmr_addr[0]) && k < 30) begin
            @(negedge clk);
            k++;
        end
        chk({nm, " data strobe seen"}, bus.mmr_write, 1);
    endtask

    initial begin
        vec_t       vecs[4];
        logic [9:0] e2[8];
        logic [9:0] e4[4];
        logic       full_at[10];
        logic       ov_at[10];
        int         n, t, k;

        vecs[0] = '{1'b0, 8'h28, 8'hF1,  0, 2'd0, 2'd1,  7};
        vecs[1] = '{1'b1, 8'h30, 8'h71,  3, 2'd2, 2'd3, 10};
        vecs[2] = '{1'b0, 8'hA4, 8'h22, 10, 2'd0, 2'd1, 17};
        vecs[3] = '{1'b1, 8'hB4, 8'hC0,  1, 2'd2, 2'd3,  8};
        e2 = '{10'h02B, 10'h100, 10'h030, 10'h171, 10'h2A4, 10'h322, 10'h0A0, 10'h169};
        e4 = '{10'h255, 10'h3AA, 10'h066, 10'h199};

        rst_n         = 1'b0;
        bus.host_wr   = 1'b0;
        bus.host_part = 1'b0;
        bus.host_reg  = 8'h00;
        bus.host_data = 8'h00;
        bus.flush     = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset level",     bus.level, 0);
        chk("reset host_full", bus.host_full, 0);
        chk("reset overflow",  bus.overflow, 0);
        chk("reset idle",      bus.idle, 1);
        chk("reset mmr_write", bus.mmr_write, 0);
        chk("reset mmr_addr",  bus.mmr_addr, 0);
        chk("reset mmr_din",   bus.mmr_din, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single writes: strobe timing relative to the push edge N
        for (int i = 0; i < 4; i++) begin
            busy_len = vecs[i].blen;
            log_q.delete();
            put(vecs[i].part, vecs[i].rg, vecs[i].dat);
            bus.host_wr = 1'b0;
            n = cyc;
            wait_idle("vec", 80);
            t = cyc;
            chk($sformatf("vec%0d idle cycle", i), t - n, vecs[i].eidle);
            chk($sformatf("vec%0d strobe count", i), log_q.size(), 2);
            if (log_q.size() >= 2) begin
                chk($sformatf("vec%0d addr cyc", i),  log_q[0].cyc - n, 2);
                chk($sformatf("vec%0d addr a", i),    log_q[0].a, vecs[i].ea0);
                chk($sformatf("vec%0d addr din", i),  log_q[0].d, vecs[i].rg);
                chk($sformatf("vec%0d data cyc", i),  log_q[1].cyc - n, 4);
                chk($sformatf("vec%0d data a", i),    log_q[1].a, vecs[i].ea1);
                chk($sformatf("vec%0d data din", i),  log_q[1].d, vecs[i].dat);
            end
        end

        // Busy pacing: queue three entries behind a stalled transaction
        busy_len   = 40;
        force_busy = 1'b1;
        log_q.delete();
        put(1'b0, 8'h2B, 8'h00);
        bus.host_wr = 1'b0;
        wait_data_strobe("pace");
        @(negedge clk);
        put(1'b0, 8'h30, 8'h71);
        put(1'b1, 8'hA4, 8'h22);
        put(1'b0, 8'hA0, 8'h69);
        bus.host_wr = 1'b0;
        @(negedge clk);
        chk("pace level 3", bus.level, 3);
        lvl_q.delete();
        force_busy = 1'b0;
        wait_idle("pace", 400);
        chk("pace strobe count", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int j = 0; j < 8; j++)
                chk($sformatf("pace strobe %0d", j), {log_q[j].a, log_q[j].d}, e2[j]);
            for (int j = 2; j < 8; j += 2)
                chk($sformatf("pace gap %0d", j), log_q[j].gap >= 2, 1);
        end
        chk("pace level trace len", lvl_q.size(), 3);
        if (lvl_q.size() == 3) begin
            chk("pace level 2", lvl_q[0], 2);
            chk("pace level 1", lvl_q[1], 1);
            chk("pace level 0", lvl_q[2], 0);
        end

        // Overflow: ten pushes against a stalled replay
        busy_len   = 5;
        force_busy = 1'b1;
        log_q.delete();
        for (int i = 0; i < 10; i++) begin
            put(1'b0, 8'h40 + 8'(i), 8'(i));
            full_at[i] = bus.host_full;
            ov_at[i]   = bus.overflow;
        end
        bus.host_wr = 1'b0;
        chk("ovf full after push 8", full_at[7], 0);
        chk("ovf full after push 9", full_at[8], 1);
        chk("ovf flag after push 9", ov_at[8], 0);
        chk("ovf flag after push 10", ov_at[9], 1);
        chk("ovf level", bus.level, 8);
        force_busy = 1'b0;
        wait_idle("ovf", 600);
        chk("ovf sticky", bus.overflow, 1);
        chk("ovf full cleared", bus.host_full, 0);
        chk("ovf strobe count", log_q.size(), 18);
        if (log_q.size() == 18) begin
            for (int j = 0; j < 9; j++) begin
                chk($sformatf("ovf addr %0d", j), {log_q[2*j].a, log_q[2*j].d}, {2'b00, 8'h40 + 8'(j)});
                chk($sformatf("ovf data %0d", j), {log_q[2*j+1].a, log_q[2*j+1].d}, {2'b01, 8'(j)});
            end
        end

        // Push coinciding with the IDLE pop at level 1
        force_busy = 1'b1;
        log_q.delete();
        put(1'b1, 8'h55, 8'hAA);
        chk("pp level before", bus.level, 1);
        put(1'b0, 8'h66, 8'h99);
        bus.host_wr = 1'b0;
        chk("pp level same", bus.level, 1);
        @(negedge clk);
        chk("pp level held", bus.level, 1);
        force_busy = 1'b0;
        wait_idle("pp", 200);
        chk("pp strobe count", log_q.size(), 4);
        if (log_q.size() == 4)
            for (int j = 0; j < 4; j++)
                chk($sformatf("pp strobe %0d", j), {log_q[j].a, log_q[j].d}, e4[j]);

        // Flush while the first transaction waits on busy
        force_busy = 1'b1;
        log_q.delete();
        for (int i = 0; i < 6; i++) put(1'b0, 8'h80 + 8'(i), 8'h10 + 8'(i));
        bus.host_wr = 1'b0;
        chk("flush level 5", bus.level, 5);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush level 0", bus.level, 0);
        force_busy = 1'b0;
        repeat (30) @(negedge clk);
        chk("flush idle", bus.idle, 1);
        chk("flush overflow kept", bus.overflow, 1);
        chk("flush strobe count", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("flush addr", {log_q[0].a, log_q[0].d}, 10'h080);
            chk("flush data", {log_q[1].a, log_q[1].d}, 10'h110);
        end

        // Asynchronous reset during the data strobe
        busy_len = 0;
        put(1'b0, 8'h11, 8'h22);
        put(1'b1, 8'h33, 8'h44);
        put(1'b0, 8'h55, 8'h66);
        bus.host_wr = 1'b0;
        wait_data_strobe("arst");
        chk("arst level before", bus.level, 2);
        rst_n = 1'b0;
        #1;
        chk("arst mmr_write", bus.mmr_write, 0);
        chk("arst level", bus.level, 0);
        chk("arst overflow", bus.overflow, 0);
        chk("arst idle", bus.idle, 1);
        @(negedge clk);
        rst_n = 1'b1;
        log_q.delete();
        k = 0;
        repeat (20) @(negedge clk);
        chk("arst no replay", log_q.size(), k);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end
endmodule
`default_nettype wire
